cl_mask_filter: RTL and testbench
=================================

CL_MASK_FILTER -- requirements
Module: cl_mask_filter

Interface
REQ-001 Parameter COMPRESSION_WINDOW_SIZE, default 32, number of positions in a compression window (W).
REQ-002 Parameter TRANSFER_SIZE, default 4, number of compressed values per transfer block (T).
REQ-003 Derived constants: CW = clog2(T)+1 (per-position count width, 3 by default); IW = clog2(W) (index width, 5 by default).
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset, sampled on rising clock.
REQ-006 in_valid  input  1  qualifies bitmask, mutual_bitmask and start_index this cycle.
REQ-007 bitmask  input  W  sparsity bitmask of the compressed stream; bit p=1 means position p holds a nonzero value.
REQ-008 mutual_bitmask  input  W  positions whose value is actually required by the consumer.
REQ-009 start_index  input  IW  first window position not yet consumed.
REQ-010 out_valid  output  1  registered in_valid.
REQ-011 dense_bitmask  output  T  per-slot select for the current transfer block.
REQ-012 next_index  output  IW  start index for the following transfer block.
REQ-013 window_done  output  1  current block exhausts the window.
REQ-014 accumulated_index  output  CW*W  per-position saturated prefix count; field p at bits [CW*p+CW-1 : CW*p].
REQ-015 pop_count  output  8  total number of ones in bitmask, zero-extended.

Function
REQ-016 All outputs SHALL be registered, with latency exactly 1 cycle from inputs sampled with in_valid=1.
REQ-017 When in_valid=0, out_valid SHALL be 0 next cycle and all other outputs SHALL hold their previous values.
REQ-018 accumulated_index field p SHALL be 0 for p < start_index; otherwise it SHALL be popcount(bitmask[p:start_index]), saturated at T.
REQ-019 Slot k (0..T-1) SHALL map to the position p_k where bitmask[p_k]=1 and field p_k equals k+1; a slot with no such position is empty.
REQ-020 dense_bitmask[k] SHALL equal mutual_bitmask[p_k] for an occupied slot and 0 for an empty slot.
REQ-021 If slot T-1 is occupied and p_{T-1} < W-1, next_index SHALL be p_{T-1}+1 and window_done SHALL be 0.
REQ-022 If slot T-1 is empty, or p_{T-1} = W-1, next_index SHALL be 0 and window_done SHALL be 1.
REQ-023 pop_count SHALL be popcount(bitmask) over all W bits, independent of start_index.
REQ-024 All logic apart from the output registers SHALL be combinational, with no further state.
REQ-025 Zero-value cases: bitmask=0 gives dense_bitmask=0, next_index=0, window_done=1 and pop_count=0.
REQ-026 The output is defined purely by bitmask, mutual_bitmask and start_index.
REQ-027 Set bits in mutual_bitmask where bitmask=0 SHALL be ignored.

Reset
REQ-028 With resetn=0 at a rising edge, every output SHALL be 0 on the next cycle (out_valid=0, dense_bitmask=0, next_index=0, window_done=0, accumulated_index=0, pop_count=0), regardless of in_valid.
REQ-029 Reset asserted mid-stream SHALL discard the pending result.
REQ-030 The first valid result after reset SHALL appear one cycle after the first in_valid=1 with resetn=1.

Verification
REQ-031 Setup: bitmask=0xFFFFFFFF, mutual_bitmask=0xF00FF00F. Feed next_index back into start_index each result, starting from 0. Required (dense_bitmask, next_index) sequence: (F,4), (0,8), (0,12), (F,16), (F,20), (0,24), (0,28), (F,0). window_done=1 only on the last entry; pop_count=32 throughout.
REQ-032 bitmask=0xFFFFFFFF, start_index=0 -> accumulated_index fields 0..3 = 1,2,3,4 and fields 4..31 = 4 (saturated).
REQ-033 bitmask=0x00000105, mutual=0xFFFFFFFF, start_index=0 -> dense_bitmask=0b0111, next_index=0, window_done=1, pop_count=3.
REQ-034 bitmask=0x80000007, mutual=0x80000000, start_index=0 -> slot 3 at position 31, dense_bitmask=0b1000, next_index=0, window_done=1.
REQ-035 Valid inputs applied, then resetn=0 for 1 cycle -> all outputs 0 next cycle; out_valid stays 0 until in_valid is reasserted.
REQ-036 bitmask=0 with any start_index -> dense_bitmask=0, next_index=0, window_done=1, pop_count=0.

Source files
------------

// File: rtl/cl_mask_filter.sv
// Sparse-window mask filter: maps the next TRANSFER_SIZE nonzero positions at or
// after start_index onto dense transfer slots, with one-cycle registered outputs.
module cl_mask_filter #(
  parameter int COMPRESSION_WINDOW_SIZE = 32,
  parameter int TRANSFER_SIZE           = 4,
  localparam int CW = $clog2(TRANSFER_SIZE) + 1,
  localparam int IW = $clog2(COMPRESSION_WINDOW_SIZE)
) (
  input  logic                                  clock,
  input  logic                                  resetn,
  input  logic                                  in_valid,
  input  logic [COMPRESSION_WINDOW_SIZE-1:0]    bitmask,
  input  logic [COMPRESSION_WINDOW_SIZE-1:0]    mutual_bitmask,
  input  logic [IW-1:0]                         start_index,
  output logic                                  out_valid,
  output logic [TRANSFER_SIZE-1:0]              dense_bitmask,
  output logic [IW-1:0]                         next_index,
  output logic                                  window_done,
  output logic [CW*COMPRESSION_WINDOW_SIZE-1:0] accumulated_index,
  output logic [7:0]                            pop_count
);

  localparam int unsigned W        = COMPRESSION_WINDOW_SIZE;
  localparam int unsigned T        = TRANSFER_SIZE;
  localparam int unsigned LAST_POS = W - 1;

  logic [CW*W-1:0] accNext;
  logic [T-1:0]    denseNext;
  logic [IW-1:0]   nextNext;
  logic            doneNext;
  logic [7:0]      popNext;
  logic [CW-1:0]   runCnt;
  logic            lastFound;
  int unsigned     lastPos;

  // runCnt is the saturated count of set bits seen so far inside the window;
  // a set bit whose prior count is k < T is the unique occupant of slot k.
  always_comb begin
    accNext   = '0;
    denseNext = '0;
    popNext   = '0;
    runCnt    = '0;
    lastFound = 1'b0;
    lastPos   = '0;
    nextNext  = '0;
    doneNext  = 1'b1;
    for (int unsigned p = 0; p < W; p++) begin
      popNext = popNext + 8'(bitmask[p]);
      if (p >= 32'(start_index) && bitmask[p]) begin
        for (int unsigned k = 0; k < T; k++) begin
          if (runCnt == CW'(k)) denseNext[k] = mutual_bitmask[p];
        end
        if (runCnt == CW'(T - 1)) begin
          lastFound = 1'b1;
          lastPos   = p;
        end
        if (runCnt != CW'(T)) runCnt = runCnt + CW'(1);
      end
      accNext[CW*p +: CW] = runCnt;
    end
    if (lastFound && lastPos != LAST_POS) begin
      nextNext = IW'(lastPos + 1);
      doneNext = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      out_valid         <= 1'b0;
      dense_bitmask     <= '0;
      next_index        <= '0;
      window_done       <= 1'b0;
      accumulated_index <= '0;
      pop_count         <= '0;
    end else if (in_valid) begin
      out_valid         <= 1'b1;
      dense_bitmask     <= denseNext;
      next_index        <= nextNext;
      window_done       <= doneNext;
      accumulated_index <= accNext;
      pop_count         <= popNext;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cl_mask_filter.sv
// Directed scoreboard bench for cl_mask_filter with default parameters (W=32, T=4).
module tb_cl_mask_filter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [31:0] bitmask;
  logic [31:0] mutual_bitmask;
  logic [4:0]  start_index;
  logic        out_valid;
  logic [3:0]  dense_bitmask;
  logic [4:0]  next_index;
  logic        window_done;
  logic [95:0] accumulated_index;
  logic [7:0]  pop_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  dense;
    logic [4:0]  nxt;
    logic        done;
    logic [7:0]  pop;
    logic [95:0] acc;
  } exp_t;

  exp_t expQ[$];

  cl_mask_filter #(.COMPRESSION_WINDOW_SIZE(32), .TRANSFER_SIZE(4)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .bitmask(bitmask),
    .mutual_bitmask(mutual_bitmask), .start_index(start_index), .out_valid(out_valid),
    .dense_bitmask(dense_bitmask), .next_index(next_index), .window_done(window_done),
    .accumulated_index(accumulated_index), .pop_count(pop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  // Reference: saturated popcount of bm over [s..p], written from the definition.
  function automatic logic [95:0] accRef(input logic [31:0] bm, input int s);
    logic [95:0] r;
    logic [31:0] lo, hi;
    int c;
    r = '0;
    for (int p = 0; p < 32; p++) begin
      if (p >= s) begin
        lo = 32'hFFFF_FFFF << s;
        hi = 32'hFFFF_FFFF >> (31 - p);
        c = $countones(bm & lo & hi);
        if (c > 4) c = 4;
        r[3*p +: 3] = 3'(c);
      end
    end
    return r;
  endfunction

  always @(negedge clock) begin
    if (out_valid) begin
      if (expQ.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        chk("dense_bitmask", dense_bitmask, e.dense);
        chk("next_index", next_index, e.nxt);
        chk("window_done", window_done, e.done);
        chk("pop_count", pop_count, e.pop);
        chk("accumulated_index", accumulated_index, e.acc);
      end
    end
  end

  task automatic send(input logic [31:0] bm, input logic [31:0] mu, input logic [4:0] s,
                      input logic [3:0] d, input logic [4:0] n, input logic dn,
                      input logic [7:0] pc);
    exp_t e;
    bitmask = bm; mutual_bitmask = mu; start_index = s; in_valid = 1'b1;
    e.dense = d; e.nxt = n; e.done = dn; e.pop = pc; e.acc = accRef(bm, int'(s));
    expQ.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic chkZero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_dense"}, dense_bitmask, 0);
    chk({tag, "_next"}, next_index, 0);
    chk({tag, "_done"}, window_done, 0);
    chk({tag, "_acc"}, accumulated_index, 0);
    chk({tag, "_pop"}, pop_count, 0);
  endtask

  logic [3:0] seqDense [8] = '{4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF};
  logic [4:0] seqNext  [8] = '{5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd24, 5'd28, 5'd0};

  initial begin
    logic [4:0] s;
    resetn = 1'b0; in_valid = 1'b1;
    bitmask = 32'hFFFF_FFFF; mutual_bitmask = 32'hFFFF_FFFF; start_index = '0;
    @(posedge clock); @(posedge clock); #1;
    chkZero("reset");
    resetn = 1'b1; in_valid = 1'b0;
    @(posedge clock); #1;
    chk("idle_out_valid", out_valid, 0);

    send(32'hFFFF_FFFF, 32'h0000_0000, 5'd0,  4'b0000, 5'd4,  1'b0, 8'd32);
    send(32'h0000_0105, 32'hFFFF_FFFF, 5'd0,  4'b0111, 5'd0,  1'b1, 8'd3);
    send(32'h8000_0007, 32'h8000_0000, 5'd0,  4'b1000, 5'd0,  1'b1, 8'd4);
    send(32'h0000_0000, 32'hFFFF_FFFF, 5'd7,  4'b0000, 5'd0,  1'b1, 8'd0);
    send(32'h0000_0000, 32'hFFFF_FFFF, 5'd0,  4'b0000, 5'd0,  1'b1, 8'd0);
    send(32'h0000_00F0, 32'h0000_005F, 5'd0,  4'b0101, 5'd8,  1'b0, 8'd4);
    send(32'h0F0F_0F0F, 32'hFFFF_FFFF, 5'd6,  4'b1111, 5'd12, 1'b0, 8'd16);
    send(32'h0000_000F, 32'hFFFF_FFFF, 5'd4,  4'b0000, 5'd0,  1'b1, 8'd4);
    send(32'h0001_0000, 32'h0001_0000, 5'd16, 4'b0001, 5'd0,  1'b1, 8'd1);
    send(32'h8000_0000, 32'h8000_0000, 5'd30, 4'b0001, 5'd0,  1'b1, 8'd1);

    // Walk the window by feeding next_index back as start_index.
    s = 5'd0;
    for (int i = 0; i < 8; i++) begin
      send(32'hFFFF_FFFF, 32'hF00F_F00F, s, seqDense[i], seqNext[i], (i == 7), 8'd32);
      s = next_index;
    end

    in_valid = 1'b0;
    bitmask = 32'h0; mutual_bitmask = 32'h0; start_index = 5'd9;
    @(posedge clock); #1;
    chk("hold_out_valid", out_valid, 0);
    chk("hold_dense", dense_bitmask, 4'hF);
    chk("hold_next", next_index, 0);
    chk("hold_done", window_done, 1);
    chk("hold_pop", pop_count, 32);
    chk("hold_acc", accumulated_index, accRef(32'hFFFF_FFFF, 28));

    // Reset while a valid input is pending discards it.
    send(32'h0000_00FF, 32'hFFFF_FFFF, 5'd0, 4'hF, 5'd4, 1'b0, 8'd8);
    bitmask = 32'hFFFF_FFFF; mutual_bitmask = 32'hFFFF_FFFF; start_index = 5'd0;
    in_valid = 1'b1; resetn = 1'b0;
    @(posedge clock); #1;
    chkZero("midreset");
    resetn = 1'b1; in_valid = 1'b0;
    @(posedge clock); #1;
    chk("postreset_out_valid", out_valid, 0);
    @(posedge clock); #1;
    chk("postreset2_out_valid", out_valid, 0);
    send(32'h0000_0003, 32'h0000_0002, 5'd1, 4'b0001, 5'd0, 1'b1, 8'd2);
    in_valid = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    chk("scoreboard_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
